dma_bus_grant_unit: RTL and testbench
=====================================

// Module: dma_bus_grant_unit
// PURPOSE
//  CPU-side responder for the DMA controller's bus-request protocol. On dma_begin_intr it issues one DMA
//  command (buffer address, length), answers the controller's br with bg once the CPU data-memory port is
//  quiescent, stalls the CPU data port while granted, and latches dma_end_intr as a CPU-visible interrupt.
//  Sits between cpu datapath, DMA controller and the shared data-memory bus.
// PARAMETERS
//  WORD_SIZE     16       data/address width
//  DMA_BUF_ADDR  16'h01F4 memory address the DMA writes to
//  DMA_LEN       12       words per transfer; multiple of BLOCK_WORDS (4)
//  LEN_W         4        width of cmd_len
// PORTS
//  clk           in   1          clock
//  reset_n       in   1          synchronous, active-low reset
//  dma_begin_intr in  1          external device has data ready (1-cycle pulse)
//  dma_end_intr  in   1          DMA controller finished transfer (1-cycle pulse)
//  br            in   1          bus request from DMA controller, level
//  blk_done      in   1          DMA controller finished one 4-word block (1-cycle pulse)
//  cpu_mem_req   in   1          CPU wants the data-memory port this cycle
//  cpu_mem_busy  in   1          CPU data access in flight, must not be cut
//  isr_ack       in   1          CPU handler clears isr_pending
//  bg            out  1          bus grant to DMA controller
//  cmd_valid     out  1          DMA command strobe, 1 cycle
//  cmd_addr      out  WORD_SIZE  = DMA_BUF_ADDR while cmd_valid, else 0
//  cmd_len       out  LEN_W      = DMA_LEN while cmd_valid, else 0
//  cpu_stall     out  1          freeze CPU data-memory port
//  isr_pending   out  1          DMA-complete interrupt to CPU, sticky
//  dma_overrun   out  1          sticky: dma_begin_intr arrived while transfer active
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state IDLE, all outputs 0, blk_cnt 0. Applies mid-transfer: bg drops next edge.
//  FSM (registered outputs, 1 state per cycle):
//   IDLE    : dma_begin_intr -> CMD.
//   CMD     : cmd_valid=1 exactly this cycle -> WAIT_BR.
//   WAIT_BR : br=1 -> DRAIN.
//   DRAIN   : cpu_stall = cpu_mem_req; cpu_mem_busy=0 -> GRANT (bg rises on this edge), else stay.
//   GRANT   : bg=1, cpu_stall=1; br=0 -> IDLE (bg low next cycle); blk_done -> blk_cnt+1.
//   STEAL   : only with DMA_CYCLE_STEAL_EN, see CONFIGURATION.
//  Latency: br seen high with cpu_mem_busy=0 -> bg high 2 edges later (WAIT_BR->DRAIN->GRANT).
//  bg never asserted while cpu_mem_busy=1; bg and cpu_mem_req never both effective (stall covers).
//  blk_cnt: 0..DMA_LEN/4, clears on entering CMD; saturates, no wrap.
//  isr_pending: set by dma_end_intr in any state; cleared by isr_ack; simultaneous set+ack -> set wins.
//  dma_overrun: set by dma_begin_intr in any state except IDLE; cleared only by reset; request ignored.
//  br dropping in DRAIN -> IDLE, no grant. br=0 in GRANT with blk_cnt<DMA_LEN/4 still exits cleanly.
// CONFIGURATION
//  DMA_CYCLE_STEAL_EN defined: in GRANT, blk_done with cpu_mem_req=1 and blk_cnt+1<DMA_LEN/4 -> STEAL:
//   bg=0, cpu_stall=0 for exactly 1 cycle, then back to GRANT if br=1, else IDLE. Last block never steals.
//  Not defined: no STEAL state; bg held continuously while br=1.
// STRUCTURE
//  Shared package dma_pkg.vh: WORD_SIZE, BLOCK_WORDS=4, FSM state encodings (3-bit), DMA_BUF_ADDR default.
//  One sub-module: dma_irq_latch (isr_pending/dma_overrun sticky flags with set-wins priority).
//  blk_cnt and FSM stay in the top module.
// TESTING
//  1 begin pulse, br 2 cyc after cmd, busy=0 -> cmd_valid 1 cyc, addr 16'h01F4, len 12; bg 2 edges after br.
//  br high while cpu_mem_busy=1 for 3 cyc -> bg stays 0 those cycles, rises the edge after busy falls.
//  3 blk_done pulses, br drops -> blk_cnt=3, bg low next cycle; dma_end_intr -> isr_pending=1 until isr_ack.
//  dma_end_intr and isr_ack same cycle -> isr_pending=1; second begin pulse mid-GRANT -> dma_overrun=1.
//  reset_n=0 during GRANT -> next edge bg=0, cpu_stall=0, isr_pending=0, state IDLE.
//  DMA_CYCLE_STEAL_EN, cpu_mem_req=1 at blk_done #1 -> bg=0 exactly 1 cycle; at blk_done #3 -> no gap.

Source files
------------

// File: rtl/dma_bus_grant_unit_pkg.sv
// ---------------------------------------------------------------------------
// dma_bus_grant_unit_pkg
// Shared constants, FSM state encoding and small helpers for the CPU-side
// DMA bus-grant responder.
//   DMA_WORD_SIZE     : data/address width of the shared data-memory bus
//   DMA_BLOCK_WORDS   : words moved by the DMA controller per blk_done pulse
//   DMA_LEN_DEF       : default transfer length in words
//   DMA_LEN_W_DEF     : default width of the command length field
//   DMA_BUF_ADDR_DEF  : default buffer address handed to the DMA controller
// Optional feature macro used by the top module: DMA_CYCLE_STEAL_EN
// ---------------------------------------------------------------------------
package dma_bus_grant_unit_pkg;

    localparam int DMA_WORD_SIZE   = 16;
    localparam int DMA_BLOCK_WORDS = 4;
    localparam int DMA_LEN_DEF     = 12;
    localparam int DMA_LEN_W_DEF   = 4;
    localparam logic [DMA_WORD_SIZE-1:0] DMA_BUF_ADDR_DEF = 16'h01F4;

    // 3-bit state encoding shared with anything that decodes the FSM.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_WAIT_BR = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_GRANT   = 3'd4,
        ST_STEAL   = 3'd5
    } dma_state_t;

    // Number of blk_done pulses that make up one full transfer.
    function automatic int blocks_per_xfer(input int len_words);
        return len_words / DMA_BLOCK_WORDS;
    endfunction

    // Width of a counter that must hold 0..blocks_per_xfer(len) inclusive.
    function automatic int blk_cnt_width(input int len_words);
        int n_blocks;
        n_blocks = len_words / DMA_BLOCK_WORDS;
        return (n_blocks < 1) ? 1 : $clog2(n_blocks + 1);
    endfunction

endpackage

// File: rtl/dma_bus_grant_unit_if.sv
// ---------------------------------------------------------------------------
// dma_bus_grant_unit_if
// Bundles the DMA-controller handshake, DMA command, CPU data-port control
// and interrupt signals seen by the bus-grant responder.
//   slave  modport : the responder (dma_bus_grant_unit)
//   master modport : the environment (DMA controller, CPU datapath, device)
// Signals:
//   dma_begin_intr  device has data ready (1-cycle pulse)
//   dma_end_intr    DMA controller finished the transfer (1-cycle pulse)
//   br              bus request from DMA controller (level)
//   blk_done        one 4-word block finished (1-cycle pulse)
//   cpu_mem_req     CPU wants the data-memory port this cycle
//   cpu_mem_busy    CPU data access in flight, must not be cut
//   isr_ack         CPU handler clears isr_pending
//   bg              bus grant to the DMA controller
//   cmd_valid       DMA command strobe (1 cycle)
//   cmd_addr        buffer address while cmd_valid, else 0
//   cmd_len         transfer length while cmd_valid, else 0
//   cpu_stall       freeze the CPU data-memory port
//   isr_pending     sticky DMA-complete interrupt
//   dma_overrun     sticky: begin request arrived during a transfer
// ---------------------------------------------------------------------------
interface dma_bus_grant_unit_if #(
    parameter int WORD_SIZE = 16,
    parameter int LEN_W     = 4
);
    logic                 dma_begin_intr;
    logic                 dma_end_intr;
    logic                 br;
    logic                 blk_done;
    logic                 cpu_mem_req;
    logic                 cpu_mem_busy;
    logic                 isr_ack;
    logic                 bg;
    logic                 cmd_valid;
    logic [WORD_SIZE-1:0] cmd_addr;
    logic [LEN_W-1:0]     cmd_len;
    logic                 cpu_stall;
    logic                 isr_pending;
    logic                 dma_overrun;

    modport slave (
        input  dma_begin_intr, dma_end_intr, br, blk_done,
               cpu_mem_req, cpu_mem_busy, isr_ack,
        output bg, cmd_valid, cmd_addr, cmd_len,
               cpu_stall, isr_pending, dma_overrun
    );

    modport master (
        output dma_begin_intr, dma_end_intr, br, blk_done,
               cpu_mem_req, cpu_mem_busy, isr_ack,
        input  bg, cmd_valid, cmd_addr, cmd_len,
               cpu_stall, isr_pending, dma_overrun
    );

endinterface

// File: rtl/dma_bus_grant_unit_irq_latch.sv
// ---------------------------------------------------------------------------
// dma_bus_grant_unit_irq_latch
// Sticky CPU-visible flags of the DMA responder.
//   clk              clock
//   reset_n          synchronous, active-low reset
//   i_dma_end_intr   sets isr_pending (wins over a same-cycle ack)
//   i_isr_ack        clears isr_pending
//   i_dma_begin_intr begin request from the device
//   i_xfer_active    responder is not idle (a transfer is in progress)
//   o_isr_pending    DMA-complete interrupt
//   o_dma_overrun    begin request seen while busy; cleared only by reset
// ---------------------------------------------------------------------------
module dma_bus_grant_unit_irq_latch (
    input  logic clk,
    input  logic reset_n,
    input  logic i_dma_end_intr,
    input  logic i_isr_ack,
    input  logic i_dma_begin_intr,
    input  logic i_xfer_active,
    output logic o_isr_pending,
    output logic o_dma_overrun
);

    logic r_isr_pending;
    logic r_dma_overrun;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_isr_pending <= 1'b0;
            r_dma_overrun <= 1'b0;
        end else begin
            // A completion arriving in the same cycle as the ack must not be lost.
            if (i_dma_end_intr) begin
                r_isr_pending <= 1'b1;
            end else if (i_isr_ack) begin
                r_isr_pending <= 1'b0;
            end
            if (i_dma_begin_intr && i_xfer_active) begin
                r_dma_overrun <= 1'b1;
            end
        end
    end

    assign o_isr_pending = r_isr_pending;
    assign o_dma_overrun = r_dma_overrun;

endmodule

// File: rtl/dma_bus_grant_unit.sv
// ---------------------------------------------------------------------------
// dma_bus_grant_unit
// CPU-side responder for the DMA controller's bus-request protocol. A begin
// pulse issues one DMA command; the controller's br is answered with bg once
// the CPU data-memory port is quiescent; the CPU data port is stalled while
// granted; dma_end_intr is latched as a CPU interrupt.
// Ports:
//   clk        clock
//   reset_n    synchronous, active-low reset
//   bus        dma_bus_grant_unit_if.slave (handshake, command, stall, irq)
//   o_blk_cnt  blocks completed in the current/last grant (saturating)
// Parameters: WORD_SIZE, DMA_BUF_ADDR, DMA_LEN (multiple of 4), LEN_W.
// Optional feature macro: DMA_CYCLE_STEAL_EN
//   defined   : a mid-transfer blk_done while the CPU requests the port
//               hands the port back to the CPU for one cycle (STEAL).
//   undefined : bg is held continuously while br stays high.
// ---------------------------------------------------------------------------
module dma_bus_grant_unit
    import dma_bus_grant_unit_pkg::*;
#(
    parameter int                   WORD_SIZE    = DMA_WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] DMA_BUF_ADDR = DMA_BUF_ADDR_DEF,
    parameter int                   DMA_LEN      = DMA_LEN_DEF,
    parameter int                   LEN_W        = DMA_LEN_W_DEF,
    localparam int                  BLK_CNT_W    = blk_cnt_width(DMA_LEN)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    dma_bus_grant_unit_if.slave  bus,
    output logic [BLK_CNT_W-1:0] o_blk_cnt
);

    localparam logic [BLK_CNT_W-1:0] BLK_MAX = BLK_CNT_W'(blocks_per_xfer(DMA_LEN));

    dma_state_t           r_state;
    dma_state_t           w_state_next;
    logic [BLK_CNT_W-1:0] r_blk_cnt;
    logic [BLK_CNT_W-1:0] w_blk_cnt_next;
    logic [BLK_CNT_W:0]   w_blk_inc;
    logic                 w_bg;
    logic                 w_cmd_valid;
    logic                 w_cpu_stall;
    logic                 w_xfer_active;

    // One extra bit so the "another block still to come" test cannot wrap.
    assign w_blk_inc = {1'b0, r_blk_cnt} + {{BLK_CNT_W{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_blk_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_blk_cnt <= w_blk_cnt_next;
        end
    end

    // bg and cmd_valid are pure decodes of the state register, so they change
    // only on clock edges. cpu_stall in DRAIN follows cpu_mem_req in the same
    // cycle so a new CPU access cannot slip in while the port is draining.
    always_comb begin
        w_state_next   = r_state;
        w_blk_cnt_next = r_blk_cnt;
        w_bg           = 1'b0;
        w_cmd_valid    = 1'b0;
        w_cpu_stall    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.dma_begin_intr) begin
                    w_state_next   = ST_CMD;
                    w_blk_cnt_next = '0;
                end
            end

            ST_CMD: begin
                w_cmd_valid  = 1'b1;
                w_state_next = ST_WAIT_BR;
            end

            ST_WAIT_BR: begin
                if (bus.br) begin
                    w_state_next = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                w_cpu_stall = bus.cpu_mem_req;
                // A withdrawn request wins over a port that just went idle.
                if (!bus.br) begin
                    w_state_next = ST_IDLE;
                end else if (!bus.cpu_mem_busy) begin
                    w_state_next = ST_GRANT;
                end
            end

            ST_GRANT: begin
                w_bg        = 1'b1;
                w_cpu_stall = 1'b1;
                if (bus.blk_done && (r_blk_cnt != BLK_MAX)) begin
                    w_blk_cnt_next = w_blk_inc[BLK_CNT_W-1:0];
                end
                if (!bus.br) begin
                    w_state_next = ST_IDLE;
                end
`ifdef DMA_CYCLE_STEAL_EN
                // The final block never steals: the transfer is about to end.
                else if (bus.blk_done && bus.cpu_mem_req &&
                         (w_blk_inc < {1'b0, BLK_MAX})) begin
                    w_state_next = ST_STEAL;
                end
`endif
            end

`ifdef DMA_CYCLE_STEAL_EN
            ST_STEAL: begin
                // Port belongs to the CPU for this single cycle.
                w_state_next = bus.br ? ST_GRANT : ST_IDLE;
            end
`endif

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_xfer_active = (r_state != ST_IDLE);

    assign bus.bg        = w_bg;
    assign bus.cmd_valid = w_cmd_valid;
    assign bus.cmd_addr  = w_cmd_valid ? DMA_BUF_ADDR : '0;
    assign bus.cmd_len   = w_cmd_valid ? LEN_W'(DMA_LEN) : '0;
    assign bus.cpu_stall = w_cpu_stall;
    assign o_blk_cnt     = r_blk_cnt;

    dma_bus_grant_unit_irq_latch u_irq_latch (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_dma_end_intr   (bus.dma_end_intr),
        .i_isr_ack        (bus.isr_ack),
        .i_dma_begin_intr (bus.dma_begin_intr),
        .i_xfer_active    (w_xfer_active),
        .o_isr_pending    (bus.isr_pending),
        .o_dma_overrun    (bus.dma_overrun)
    );

endmodule

// File: tb/tb_dma_bus_grant_unit.sv
// ---------------------------------------------------------------------------
// tb_dma_bus_grant_unit
// Directed and randomized transfers against dma_bus_grant_unit. Expected
// outputs come from a transfer-level timeline: the bench knows which phase
// of a transfer it is driving and what the outputs must be in that phase;
// the sticky interrupt flags are tracked from the pulses the bench drives.
// ---------------------------------------------------------------------------
module tb_dma_bus_grant_unit;

    localparam int          BLKS     = 12 / 4;
    localparam logic [15:0] BUF_ADDR = 16'h01F4;
    localparam logic [3:0]  XFER_LEN = 4'd12;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] blk_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // expected outputs
    logic e_bg, e_stall, e_cmd, e_isr, e_ovr;
    int   e_blk;
    bit   m_active;   // bench believes a transfer is in progress

    dma_bus_grant_unit_if bus ();

    dma_bus_grant_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .o_blk_cnt (blk_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic rbit(input int pct);
        return ($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/bg"},          32'(bus.bg),          32'(e_bg));
        chk({tag, "/cmd_valid"},   32'(bus.cmd_valid),   32'(e_cmd));
        chk({tag, "/cmd_addr"},    32'(bus.cmd_addr),    e_cmd ? 32'(BUF_ADDR) : 32'd0);
        chk({tag, "/cmd_len"},     32'(bus.cmd_len),     e_cmd ? 32'(XFER_LEN) : 32'd0);
        chk({tag, "/cpu_stall"},   32'(bus.cpu_stall),   32'(e_stall));
        chk({tag, "/isr_pending"}, 32'(bus.isr_pending), 32'(e_isr));
        chk({tag, "/dma_overrun"}, 32'(bus.dma_overrun), 32'(e_ovr));
        chk({tag, "/blk_cnt"},     32'(blk_cnt),         32'(e_blk));
    endtask

    // Advance one clock; sticky flag expectations follow the pulses driven
    // before the edge. Outputs are sampled 1 time unit after the edge.
    task automatic tick();
        if (!reset_n) begin
            e_isr = 1'b0;
            e_ovr = 1'b0;
        end else begin
            if (bus.dma_end_intr)      e_isr = 1'b1;
            else if (bus.isr_ack)      e_isr = 1'b0;
            if (bus.dma_begin_intr && m_active) e_ovr = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        bus.dma_begin_intr = 1'b0;
        bus.dma_end_intr   = 1'b0;
        bus.isr_ack        = 1'b0;
        bus.blk_done       = 1'b0;
    endtask

    // Start a transfer and follow it through command, br wait and drain.
    task automatic to_grant(input int d_br, input int n_busy, input bit drop, output bit granted);
        bus.dma_begin_intr = 1'b1;
        bus.cpu_mem_req    = rbit(50);
        tick();
        bus.dma_begin_intr = 1'b0;
        m_active = 1'b1; e_cmd = 1'b1; e_blk = 0; e_bg = 1'b0; e_stall = 1'b0;
        check_all("cmd");
        e_cmd = 1'b0;
        bus.cpu_mem_req = rbit(50);
        tick();
        check_all("wait_br");
        for (int i = 0; i < d_br; i++) begin
            bus.cpu_mem_req = rbit(50);
            tick();
            check_all("wait_br_hold");
        end
        bus.br           = 1'b1;
        bus.cpu_mem_busy = (n_busy > 0);
        bus.cpu_mem_req  = rbit(50);
        tick();
        e_stall = bus.cpu_mem_req;
        check_all("drain");
        for (int i = 0; i < n_busy; i++) begin
            bus.cpu_mem_busy = 1'b1;
            bus.cpu_mem_req  = rbit(50);
            tick();
            e_stall = bus.cpu_mem_req;
            check_all("drain_busy");
        end
        bus.cpu_mem_busy = 1'b0;
        bus.cpu_mem_req  = rbit(50);
        if (drop) begin
            bus.br = 1'b0;
            tick();
            m_active = 1'b0; e_stall = 1'b0;
            check_all("drain_drop");
            granted = 1'b0;
        end else begin
            tick();
            e_bg = 1'b1; e_stall = 1'b1;
            check_all("grant");
            granted = 1'b1;
        end
    endtask

    // Hold the grant across nblk blk_done pulses with random gaps.
    task automatic grant_phase(input int nblk, input bit noisy);
        for (int b = 0; b < nblk; b++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                bus.cpu_mem_req = rbit(50);
                if (noisy) begin
                    bus.dma_end_intr   = rbit(15);
                    bus.isr_ack        = rbit(25);
                    bus.dma_begin_intr = rbit(10);
                end
                tick();
                clear_pulses();
                check_all("grant_hold");
            end
            bus.blk_done = 1'b1;
`ifdef DMA_CYCLE_STEAL_EN
            bus.cpu_mem_req = 1'b0;
`else
            bus.cpu_mem_req = 1'b1;   // must not open a gap without the steal feature
`endif
            if (noisy) begin
                bus.dma_end_intr = rbit(15);
                bus.isr_ack      = rbit(25);
            end
            tick();
            clear_pulses();
            e_blk = (e_blk + 1 > BLKS) ? BLKS : e_blk + 1;
            check_all("blk_done");
        end
    endtask

    task automatic release_bus();
        bus.br          = 1'b0;
        bus.cpu_mem_req = rbit(50);
        tick();
        m_active = 1'b0; e_bg = 1'b0; e_stall = 1'b0;
        check_all("release");
    endtask

    initial begin
        bit granted;
        clear_pulses();
        bus.br = 1'b0; bus.cpu_mem_req = 1'b0; bus.cpu_mem_busy = 1'b0;
        e_bg = 0; e_stall = 0; e_cmd = 0; e_isr = 0; e_ovr = 0; e_blk = 0; m_active = 0;

        // reset state
        reset_n = 1'b0;
        tick(); tick();
        check_all("reset");
        reset_n = 1'b1;
        tick();
        check_all("idle");

        // br two cycles after the command, port idle, three blocks
        to_grant(2, 0, 1'b0, granted);
        grant_phase(3, 1'b0);
        release_bus();
        $display("xfer directed_basic: granted=%0d blk_cnt=%0d", granted, blk_cnt);

        // completion interrupt held until acknowledged
        bus.dma_end_intr = 1'b1; tick(); clear_pulses(); check_all("isr_set");
        tick(); check_all("isr_hold");
        bus.isr_ack = 1'b1; tick(); clear_pulses(); check_all("isr_ack");

        // CPU access in flight for three cycles delays the grant
        to_grant(0, 3, 1'b0, granted);
        grant_phase(1, 1'b0);
        release_bus();
        $display("xfer directed_busy: granted=%0d blk_cnt=%0d", granted, blk_cnt);

        // set and acknowledge in the same cycle: set wins
        bus.dma_end_intr = 1'b1; bus.isr_ack = 1'b1; tick(); clear_pulses(); check_all("isr_set_wins");
        bus.isr_ack = 1'b1; tick(); clear_pulses(); check_all("isr_clear");

        // second begin pulse while granted
        to_grant(1, 0, 1'b0, granted);
        bus.dma_begin_intr = 1'b1; tick(); clear_pulses(); check_all("overrun");
        grant_phase(4, 1'b0);
        release_bus();
        $display("xfer directed_overrun: overrun=%0d blk_cnt=%0d", bus.dma_overrun, blk_cnt);

        // br withdrawn while draining: no grant
        to_grant(1, 1, 1'b1, granted);
        $display("xfer directed_drop: granted=%0d", granted);

        // reset while granted
        to_grant(0, 0, 1'b0, granted);
        bus.dma_end_intr = 1'b1; bus.blk_done = 1'b1; tick(); clear_pulses();
        e_blk = 1; check_all("pre_reset_grant");
        reset_n = 1'b0;
        tick();
        m_active = 1'b0; e_bg = 1'b0; e_stall = 1'b0; e_blk = 0;
        check_all("reset_in_grant");
        reset_n = 1'b1;
        tick();
        check_all("after_reset");
        bus.br = 1'b0;
        $display("xfer directed_reset: bg=%0d", bus.bg);

`ifdef DMA_CYCLE_STEAL_EN
        // one-cycle gap on an early block, none on the last
        to_grant(0, 0, 1'b0, granted);
        bus.blk_done = 1'b1; bus.cpu_mem_req = 1'b1; tick(); clear_pulses(); bus.cpu_mem_req = 1'b0;
        e_blk = 1; e_bg = 1'b0; e_stall = 1'b0; check_all("steal_gap");
        tick(); e_bg = 1'b1; e_stall = 1'b1; check_all("steal_back");
        bus.blk_done = 1'b1; tick(); clear_pulses(); e_blk = 2; check_all("blk2_no_req");
        bus.blk_done = 1'b1; bus.cpu_mem_req = 1'b1; tick(); clear_pulses(); bus.cpu_mem_req = 1'b0;
        e_blk = 3; check_all("last_no_steal");
        release_bus();
        $display("xfer directed_steal: blk_cnt=%0d", blk_cnt);
`endif

        // randomized transfers
        for (int t = 0; t < 40; t++) begin
            int d_br, n_busy, nblk;
            bit drop;
            d_br   = int'($urandom_range(0, 3));
            n_busy = int'($urandom_range(0, 3));
            nblk   = int'($urandom_range(0, 4));
            drop   = rbit(20);
            to_grant(d_br, n_busy, drop, granted);
            if (granted) begin
                grant_phase(nblk, 1'b1);
                release_bus();
            end
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                bus.cpu_mem_req  = rbit(50);
                bus.dma_end_intr = rbit(20);
                bus.isr_ack      = rbit(30);
                tick();
                clear_pulses();
                check_all("idle_gap");
            end
            $display("xfer %0d: d_br=%0d busy=%0d drop=%0d blocks=%0d blk_cnt=%0d isr=%0d",
                     t, d_br, n_busy, drop, nblk, blk_cnt, bus.isr_pending);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
